instruction_fetch_unit: RTL
===========================

// Module: instruction_fetch_unit
// PURPOSE
//   Initiator side of the instruction-memory read interface in the multicycle RISC core.
//   Holds the PC and drives the byte address to InstructionMemory (one word every 4 bytes).
//   Waits a fixed memory latency, then latches the returned word into IR for decode.
//   Sequenced by the control unit through fetch_req and pc_write.
// PARAMETERS
//   WORD_SIZE    32  width of PC, address and instruction
//   MEM_LATENCY   0  extra wait cycles before IR capture; legal range 0..15 (4-bit counter)
//   RESET_PC      0  PC value after reset; must be word-aligned
// PORTS
//   clk               in   1   single clock; all state updates on rising edge
//   reset             in   1   asynchronous, active-high reset
//   fetch_req         in   1   control requests fetch of the word at pc
//   pc_write          in   1   load pc from pc_next this edge
//   pc_next           in   32  new PC (branch/jump/return target)
//   imem_instruction  in   32  word returned by instruction memory
//   imem_address      out  32  byte address to instruction memory (registered)
//   pc                out  32  current program counter
//   pc_plus4          out  32  fetch_pc + 4 of the last captured instruction
//   ir                out  32  instruction register
//   ir_valid          out  1   ir holds a fresh instruction
//   busy              out  1   fetch in flight (state WAIT)
//   align_fault       out  1   one-cycle pulse: fetch_req refused, pc[1:0] != 0
// BEHAVIOUR
//   Reset (async, immediate): pc=RESET_PC, imem_address=RESET_PC, ir=0, pc_plus4=0,
//     ir_valid=0, busy=0, align_fault=0, state=IDLE, cnt=0, redirect_pending=0.
//   States: IDLE, WAIT. busy = (state==WAIT).
//   IDLE, fetch_req=1, pc[1:0]==0 (edge E0): imem_address<=pc, fetch_pc<=pc, cnt<=MEM_LATENCY,
//     ir_valid<=0, state<=WAIT.
//   IDLE, fetch_req=1, pc[1:0]!=0: align_fault<=1 for exactly one cycle; state, ir, ir_valid, pc unchanged.
//   align_fault is 0 in every other cycle.
//   WAIT, cnt!=0: cnt<=cnt-1. WAIT, cnt==0 (capture edge E(1+MEM_LATENCY)):
//     ir<=imem_instruction, pc_plus4<=fetch_pc+4, ir_valid<=1, state<=IDLE.
//   Latency: ir_valid visible MEM_LATENCY+1 cycles after the accepting edge.
//   PC update at capture: pc<=fetch_pc+4 unless pc_write is high that edge or redirect_pending=1.
//   pc_write=1 in any state: pc<=pc_next. Beats the capture auto-increment on the same edge.
//   pc_write during WAIT before capture: sets redirect_pending. The in-flight fetch still completes
//     from the latched imem_address; capture does not increment pc; redirect_pending clears at capture.
//   fetch_req while busy: ignored, no queuing, no fault.
//   fetch_req and pc_write on the same IDLE edge: fetch uses the old pc; pc<=pc_next;
//     redirect_pending<=1, so the capture keeps pc_next.
//   ir_valid stays 1 and ir stays stable until the next accepted fetch_req; no consumer ack.
//   Arithmetic is modulo 2^32: pc 0xFFFFFFFC + 4 wraps to 0x00000000 without a flag.
//   imem_address changes only on an accepting edge; it is stable through WAIT.
//   Reset asserted mid-WAIT aborts the fetch: ir is not captured and all outputs return to reset values.
// TESTING
//   Reset, then fetch_req pulse, MEM_LATENCY=0 -> imem_address=0; next edge ir=0x0C000000,
//     ir_valid=1, pc=4, pc_plus4=4.
//   Second fetch with MEM_LATENCY=3 -> busy for 4 cycles; ir=0x14400000 captured on the 4th edge; pc=8.
//   pc_write pc_next=44 while in WAIT fetching addr 8 -> ir=word@8; pc stays 44 after capture;
//     next fetch gives ir=0x3000002C.
//   pc_write pc_next=0x32, then fetch_req -> align_fault one-cycle pulse, ir_valid unchanged,
//     state stays IDLE.
//   fetch_req held high during WAIT -> no second fetch; exactly one capture per accepted request.
//   reset asserted 1 cycle into WAIT (MEM_LATENCY=2) -> outputs reset immediately, no capture;
//     pc=RESET_PC on release.

Source files
------------

// File: rtl/instruction_fetch_unit_if.sv
// Instruction-fetch bus between the control side / instruction memory and the fetch unit.
// The fetch unit connects through the slave modport; the sequencer and memory drive the master side.
interface instruction_fetch_unit_if #(
  parameter int WORD_SIZE = 32
);
  logic                 fetch_req;
  logic                 pc_write;
  logic [WORD_SIZE-1:0] pc_next;
  logic [WORD_SIZE-1:0] imem_instruction;
  logic [WORD_SIZE-1:0] imem_address;
  logic [WORD_SIZE-1:0] pc;
  logic [WORD_SIZE-1:0] pc_plus4;
  logic [WORD_SIZE-1:0] ir;
  logic                 ir_valid;
  logic                 busy;
  logic                 align_fault;

  modport master (
    output fetch_req, pc_write, pc_next, imem_instruction,
    input  imem_address, pc, pc_plus4, ir, ir_valid, busy, align_fault
  );

  modport slave (
    input  fetch_req, pc_write, pc_next, imem_instruction,
    output imem_address, pc, pc_plus4, ir, ir_valid, busy, align_fault
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch unit of the multicycle core: holds the PC, issues a word fetch, waits a fixed
// memory latency, then latches the returned word into IR.
module instruction_fetch_unit #(
  parameter int                   WORD_SIZE   = 32,
  parameter int                   MEM_LATENCY = 0,
  parameter logic [WORD_SIZE-1:0] RESET_PC    = '0
) (
  input logic                clk,
  input logic                reset,
  instruction_fetch_unit_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t               state, state_next;
  logic [3:0]           cnt;
  logic [WORD_SIZE-1:0] fetch_pc;
  logic [WORD_SIZE-1:0] fetch_pc_inc;
  logic                 redirect_pending;
  logic                 accept, fault, capture;

  assign fetch_pc_inc = fetch_pc + WORD_SIZE'(4);
  assign bus.busy     = (state == WAIT);

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    fault      = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.fetch_req) begin
          if (bus.pc[1:0] == 2'b00) begin
            accept     = 1'b1;
            state_next = WAIT;
          end else begin
            fault = 1'b1;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          capture    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      cnt              <= 4'd0;
      fetch_pc         <= RESET_PC;
      redirect_pending <= 1'b0;
      bus.pc           <= RESET_PC;
      bus.imem_address <= RESET_PC;
      bus.ir           <= '0;
      bus.pc_plus4     <= '0;
      bus.ir_valid     <= 1'b0;
      bus.align_fault  <= 1'b0;
    end else begin
      state           <= state_next;
      bus.align_fault <= fault;

      if (accept) begin
        bus.imem_address <= bus.pc;
        fetch_pc         <= bus.pc;
        cnt              <= 4'(MEM_LATENCY);
        bus.ir_valid     <= 1'b0;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end

      if (capture) begin
        bus.ir       <= bus.imem_instruction;
        bus.pc_plus4 <= fetch_pc_inc;
        bus.ir_valid <= 1'b1;
      end

      // An explicit PC write always wins; a redirect seen earlier in the fetch suppresses the increment.
      if (bus.pc_write)
        bus.pc <= bus.pc_next;
      else if (capture && !redirect_pending)
        bus.pc <= fetch_pc_inc;

      if (capture)
        redirect_pending <= 1'b0;
      else if (bus.pc_write && (state == WAIT || accept))
        redirect_pending <= 1'b1;
    end
  end

endmodule
